// File: rtl/regfile_wport_ctrl.sv
// Register-file write-port arbiter: WB vs. one buffered long-latency result, with starvation guard.
// Define REGFILE_WPORT_CLEAR_EN to include the post-reset x1..x(REG_NUM-1) clear sequencer.
module regfile_wport_ctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic              pend_valid_o,
  output logic [ADDR_W-1:0] pend_addr_o
);

  localparam int unsigned CNT_W = 4;

  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [CNT_W-1:0]  r_starve;

  logic w_run;
  logic w_wb_req;
  logic w_lu_keep;
  logic w_force;
  logic w_same;
  logic w_drain;
  logic w_drop;
  logic w_blocked;
  logic w_accept;

`ifdef REGFILE_WPORT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              w_clr;

  // Clear sequencer: one zero write per cycle from x1 up to the last register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_CLEAR;
      r_idx   <= ADDR_W'(1);
    end else if (r_state == ST_CLEAR) begin
      r_idx <= r_idx + ADDR_W'(1);
      if (r_idx == ADDR_W'(REG_NUM - 1)) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign w_clr  = !rst_i && (r_state == ST_CLEAR);
  assign w_run  = !rst_i && (r_state == ST_RUN);
  assign busy_o = rst_i || (r_state == ST_CLEAR);
`else
  assign w_run  = !rst_i;
  assign busy_o = 1'b0;
`endif

  // x0 and addresses beyond the implemented file are never written
  assign w_wb_req  = wb_we_i && (wb_addr_i != '0) && (32'(wb_addr_i) < REG_NUM);
  assign w_lu_keep = (lu_addr_i != '0) && (32'(lu_addr_i) < REG_NUM);

  assign w_force   = r_pend_valid && (r_starve == CNT_W'(STARVE_MAX));
  assign w_same    = (wb_addr_i == r_pend_addr);
  assign w_drain   = w_run && r_pend_valid && (w_force || !w_wb_req);
  assign w_drop    = w_run && r_pend_valid && !w_force && w_wb_req && w_same;
  assign w_blocked = w_run && r_pend_valid && !w_force && w_wb_req && !w_same;

  assign lu_ready_o = w_run && !r_pend_valid;
  assign w_accept   = lu_valid_i && lu_ready_o;

  // Write-port mux: clear, forced drain, WB, opportunistic drain
  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = '0;
    rf_data_o = '0;
    stall_o   = 1'b0;
`ifdef REGFILE_WPORT_CLEAR_EN
    if (w_clr) begin
      rf_we_o   = 1'b1;
      rf_addr_o = r_idx;
    end
`endif
    if (w_run) begin
      if (w_force) begin
        rf_we_o   = 1'b1;
        rf_addr_o = r_pend_addr;
        rf_data_o = r_pend_data;
        stall_o   = 1'b1;
      end else if (w_wb_req) begin
        rf_we_o   = 1'b1;
        rf_addr_o = wb_addr_i;
        rf_data_o = wb_data_i;
      end else if (r_pend_valid) begin
        rf_we_o   = 1'b1;
        rf_addr_o = r_pend_addr;
        rf_data_o = r_pend_data;
      end
    end
  end

  // Holding register and starvation counter; accept only happens when empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_starve     <= '0;
    end else begin
      if (w_drain || w_drop) begin
        r_pend_valid <= 1'b0;
        r_starve     <= '0;
      end else if (w_blocked) begin
        r_starve <= r_starve + CNT_W'(1);
      end
      if (w_accept && w_lu_keep) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= lu_addr_i;
        r_pend_data  <= lu_data_i;
        r_starve     <= '0;
      end
    end
  end

  assign pend_valid_o = r_pend_valid && !rst_i;
  assign pend_addr_o  = pend_valid_o ? r_pend_addr : '0;

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Directed bench for regfile_wport_ctrl: vector table plus clear/reset and streaming sequences.
module tb_regfile_wport_ctrl;

`ifdef REGFILE_WPORT_CLEAR_EN
  localparam logic CLEAR_ON = 1'b1;
`else
  localparam logic CLEAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        stall_o;
  logic        busy_o;
  logic        pend_valid_o;
  logic [4:0]  pend_addr_o;

  int total = 0;
  int bad   = 0;

  regfile_wport_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .wb_we_i     (wb_we_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .lu_valid_i  (lu_valid_i),
    .lu_addr_i   (lu_addr_i),
    .lu_data_i   (lu_data_i),
    .lu_ready_o  (lu_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_addr_o   (rf_addr_o),
    .rf_data_o   (rf_data_o),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .pend_valid_o(pend_valid_o),
    .pend_addr_o (pend_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic        rst;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_rdy;
    logic        e_pv;
    logic [4:0]  e_pa;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic wwe, input logic [4:0] wa,
                              input logic [31:0] wd, input logic lv, input logic [4:0] la,
                              input logic [31:0] ld, input logic e_we, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input logic e_stall, input logic e_rdy,
                              input logic e_pv, input logic [4:0] e_pa);
    vec_t v;
    v.rst = rst; v.wwe = wwe; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_stall = e_stall;
    v.e_rdy = e_rdy; v.e_pv = e_pv; v.e_pa = e_pa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Address/data fields are only constrained when a write or reset makes them meaningful
  task automatic chk_all(input string tag, input logic in_rst, input logic e_we,
                         input logic [4:0] e_addr, input logic [31:0] e_data, input logic e_stall,
                         input logic e_rdy, input logic e_pv, input logic [4:0] e_pa,
                         input logic e_busy);
    chk({tag, "_we"}, 32'(rf_we_o), 32'(e_we));
    if (e_we || in_rst) begin
      chk({tag, "_addr"}, 32'(rf_addr_o), 32'(e_addr));
      chk({tag, "_data"}, rf_data_o, e_data);
    end
    chk({tag, "_stall"}, 32'(stall_o), 32'(e_stall));
    chk({tag, "_rdy"}, 32'(lu_ready_o), 32'(e_rdy));
    chk({tag, "_pv"}, 32'(pend_valid_o), 32'(e_pv));
    if (e_pv || in_rst) chk({tag, "_pa"}, 32'(pend_addr_o), 32'(e_pa));
    chk({tag, "_busy"}, 32'(busy_o), 32'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    lu_valid_i = 1'b0; lu_addr_i = '0; lu_data_i = '0;
  endtask

  // Expects the clear sequence to start at the current cycle (rst already low)
  task automatic run_clear(input string tag);
    idle_inputs();
    rst_i = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #2;
      chk_all($sformatf("%s_c%0d", tag, k), 1'b0, 1'b1, 5'(k), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      step();
    end
  endtask

  initial begin
    // rst wwe wa wd lv la ld | we addr data stall rdy pv pa
    vq.push_back(mk(1, 0, 0, 0, 1, 5, 32'h99,       0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 0, 1, 5));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h1234,     0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 9, 32'hAA,       0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 9, 32'h11, 0, 0, 0,       1, 9, 32'h11, 0, 0, 1, 9));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 4, 32'h44,       0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 32'h55, 0, 0, 0,       1, 4, 32'h44, 0, 0, 1, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 12, 32'hC0FFEE, 0, 0, 0,  1, 12, 32'hC0FFEE, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 3, 32'h33, 1, 7, 32'h77,  1, 3, 32'h33, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0,     1, 3, 32'h33, 0, 0, 1, 7));
    vq.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0,       1, 7, 32'h77, 1, 0, 1, 7));
    vq.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0,       1, 3, 32'h33, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8, 32'h88,       0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 11, 32'hB0, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 11, 32'hB1, 0, 0, 0,      1, 11, 32'hB1, 0, 0, 1, 10));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 10, 32'hA0, 0, 0, 1, 10));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));

    idle_inputs();
    rst_i = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (CLEAR_ON && i > 0 && vq[i-1].rst && !vq[i].rst) run_clear($sformatf("r%0d", i));
      rst_i      = vq[i].rst;
      wb_we_i    = vq[i].wwe;
      wb_addr_i  = vq[i].wa;
      wb_data_i  = vq[i].wd;
      lu_valid_i = vq[i].lv;
      lu_addr_i  = vq[i].la;
      lu_data_i  = vq[i].ld;
      #2;
      chk_all($sformatf("r%0d", i), vq[i].rst, vq[i].e_we, vq[i].e_addr, vq[i].e_data,
              vq[i].e_stall, vq[i].e_rdy, vq[i].e_pv, vq[i].e_pa, vq[i].rst ? CLEAR_ON : 1'b0);
      step();
    end

    // Back-to-back long-latency results: second one waits one cycle for the slot
    idle_inputs();
    lu_valid_i = 1'b1; lu_addr_i = 5'd20; lu_data_i = 32'h2020;
    #2;
    chk_all("s0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    lu_addr_i = 5'd21; lu_data_i = 32'h2121;
    #2;
    chk_all("s1", 1'b0, 1'b1, 5'd20, 32'h2020, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
    step();
    #2;
    chk_all("s2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    lu_valid_i = 1'b0;
    #2;
    chk_all("s3", 1'b0, 1'b1, 5'd21, 32'h2121, 1'b0, 1'b0, 1'b1, 5'd21, 1'b0);
    step();
    #2;
    chk_all("s4", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step();

    // Reset mid-clear restarts the sweep at x1
    if (CLEAR_ON) begin
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        #2;
        chk_all($sformatf("m%0d", k), 1'b0, 1'b1, 5'(k), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        if (k < 10) step();
      end
      rst_i = 1'b1;
      #1;
      chk_all("m_rst", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      step();
      run_clear("m");
      #2;
      chk_all("m_done", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wport_ctrl.md
# regfile_wport_ctrl

Write-port controller for the integer register file. It owns the file's single write port and shares it between the pipeline WB stage and one long-latency result source (divider / load-miss return), buffering the latter in a one-entry holding register. It also sequences an optional post-reset clear of x1..x31 and guarantees that a buffered write eventually drains. It sits between WB, the long-latency unit and the register file, and exports pending-write status to the hazard unit.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- REG_NUM, 32, number of architectural registers
- STARVE_MAX, 4, consecutive blocked cycles before the buffered write is forced through (1..15)

- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- wb_we_i  in  1  WB write request
- wb_addr_i  in  ADDR_W  WB destination
- wb_data_i  in  DATA_W  WB data
- lu_valid_i  in  1  long-latency result valid
- lu_addr_i  in  ADDR_W  long-latency destination
- lu_data_i  in  DATA_W  long-latency data
- lu_ready_o  out  1  holding register empty; result accepted on valid&&ready
- rf_we_o  out  1  write enable to register file
- rf_addr_o  out  ADDR_W  write address
- rf_data_o  out  DATA_W  write data
- stall_o  out  1  WB must hold; WB write not performed this cycle
- busy_o  out  1  clear sequence running; pipeline frozen
- pend_valid_o  out  1  holding register occupied
- pend_addr_o  out  ADDR_W  destination of held write

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR (RUN when clear is compiled out).
- CLEAR: 5-bit index starts at 1; each cycle rf_we_o=1, rf_addr_o=index, rf_data_o=0; index increments; after writing REG_NUM-1 moves to RUN. busy_o=1, lu_ready_o=0, stall_o=0. WB inputs are ignored.
- RUN arbitration, highest first:
  - Held entry with starve count == STARVE_MAX: drive held write, stall_o=1.
  - WB with wb_we_i=1 and wb_addr_i!=0: drive WB write.
  - Held entry: drive held write.
  - Otherwise: rf_we_o=0.
- Writes to x0 never assert rf_we_o: a WB write to x0 counts as no request; an lu write to x0 is accepted and discarded (not held).
- Holding register: loads on lu_valid_i && lu_ready_o; lu_ready_o = !pend_valid in RUN. No same-cycle pass-through; a held entry drains no earlier than the cycle after acceptance.
- Held entry clears at the posedge it is written. If WB writes the same address as the held entry while it is blocked, the held entry is dropped in that cycle (younger WB wins WAW).
- Starve counter: 4 bits, increments each cycle the held entry is blocked by WB, clears on drain/drop/reset. Never exceeds STARVE_MAX.
- On stall_o=1, WB holds wb_* unchanged; the WB write is performed on a later cycle.

## Timing
- rf_*, stall_o and lu_ready_o are combinational from state and inputs. All state updates occur on the rising clock edge.
- While rst_i=1: rf_we_o=0, stall_o=0, lu_ready_o=0, pend_valid_o=0, pend_addr_o=0, rf_addr_o=0, rf_data_o=0. busy_o=1 if clear is enabled, else 0.
- Clear latency: REG_NUM-1 cycles (31) after rst_i falls; busy_o drops in cycle 32.
- Forced drain: at most STARVE_MAX+1 cycles after acceptance.
- Reset mid-CLEAR restarts the clear at index 1. Reset mid-RUN discards the held entry.

## Configuration
- REGFILE_WPORT_CLEAR_EN defined: CLEAR state and sequencer are present.
- Not defined: reset goes directly to RUN, busy_o is tied to 0, and the index counter is removed.

## Test plan
- Reset with clear enabled → rf_we_o=1 for 31 cycles with addrs 1..31 and data 0; busy_o=0 from cycle 32; lu_ready_o=1.
- Idle RUN, lu_valid_i=1, lu_addr_i=5, lu_data_i=0xDEADBEEF → accepted; next cycle rf_we_o=1, addr 5, data 0xDEADBEEF; lu_ready_o=0 for exactly that one cycle.
- Held entry for x7 with WB writing x3 every cycle → WB wins 4 cycles; cycle 5 stall_o=1 and x7 written; held WB x3 write occurs the following cycle.
- Held entry for x9, WB writes x9=0x11 → rf writes 0x11 to x9; held entry dropped; pend_valid_o=0 next cycle; no second write to x9.
- WB write x0 with held entry x4 → held entry drains that cycle. lu write to x0 → lu_ready_o stays 1 and no rf write occurs.
- rst_i asserted at clear index 10 → after release, clear restarts at addr 1; full 31 cycles complete.
